// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS pipeline control slice: FSM state encoding,
// register-address width and the SPECIAL-opcode functs for the HI/LO unit.
package mips_ctrl_pkg;

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_MULDIV = 1'b1;

    localparam int REG_ADDR_W = 5;

    // Wide enough for MULDIV_LATENCY-1 over the whole legal 1..15 range.
    localparam int LAT_CNT_W = 4;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    // Decoder helper: SPECIAL funct that starts the mult/div unit.
    function automatic logic is_muldiv_funct(input logic [5:0] funct);
        return (funct == FN_MULT) || (funct == FN_MULTU) ||
               (funct == FN_DIV)  || (funct == FN_DIVU);
    endfunction

    // Decoder helper: SPECIAL funct that reads HI or LO.
    function automatic logic is_hilo_read_funct(input logic [5:0] funct);
        return (funct == FN_MFHI) || (funct == FN_MFLO);
    endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating performance counter of pipeline stall cycles.
// Clear wins over increment; the count sticks at all-ones.
module stall_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count bubble cycles, hold at saturation, synchronous clear first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Inserts load-use bubbles, flushes IF/ID on taken branches/jumps,
// sequences the multi-cycle mult/div unit and counts stall cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | HI/LO idle, result valid; mult/div may be issued from ID
// MULDIV | mult/div in flight; HI/LO readers and new mult/div stall
module hazard_stall_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  IFID_UsesRt,
    input  logic                  IFID_ReadsHiLo,
    input  logic                  MulDiv_Start,
    input  logic                  Branch_Taken,
    input  logic                  Jump,
    input  logic                  Stall_Clear,
    output logic                  PC_Write,
    output logic                  IFID_Write,
    output logic                  IFID_Flush,
    output logic                  IDEX_Bubble,
    output logic                  MulDiv_Busy,
    output logic                  HiLo_Valid,
    output logic [CNT_W-1:0]      Stall_Count
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MULDIV_LATENCY - 1);

    logic                 r_state;
    logic                 w_next_state;
    logic [LAT_CNT_W-1:0] r_remain;
    logic [LAT_CNT_W-1:0] w_next_remain;
    logic                 r_hilo_valid;

    logic w_lu;
    logic w_hl;
    logic w_stall;
    logic w_flush;
    logic w_issue;

    // Load-use that forwarding cannot cover; $0 is never a real dependency.
    assign w_lu = IDEX_MemRead && (IDEX_Rt != '0) &&
                  ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    // HI/LO is unusable while the unit is busy, for readers and new starts alike.
    assign w_hl = (r_state == ST_MULDIV) && (IFID_ReadsHiLo || MulDiv_Start);

    assign w_stall = w_lu || w_hl;

    // Branch/jump operands are stale during a stall, so the redirect waits.
    assign w_flush = !w_stall && (Branch_Taken || Jump);

    // A start that is stalled or flushed away is simply not issued.
    assign w_issue = (r_state == ST_RUN) && MulDiv_Start && !w_stall && !w_flush;

    // State register, latency down-counter and registered HI/LO valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_remain     <= '0;
            r_hilo_valid <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_remain     <= w_next_remain;
            r_hilo_valid <= (w_next_state == ST_RUN);
        end
    end

    // Next-state: issue loads the latency, MULDIV counts down to terminal zero.
    always_comb begin
        w_next_state  = r_state;
        w_next_remain = r_remain;
        case (r_state)
            ST_RUN: begin
                if (w_issue) begin
                    w_next_state  = ST_MULDIV;
                    w_next_remain = LAT_LOAD;
                end
            end
            ST_MULDIV: begin
                if (r_remain == '0) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_remain = r_remain - 1'b1;
                end
            end
            default: begin
                w_next_state  = ST_RUN;
                w_next_remain = '0;
            end
        endcase
    end

    // Pipeline control outputs; all purely combinational on state and inputs.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        MulDiv_Busy = (r_state == ST_MULDIV);
        if (w_stall) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (w_flush) begin
            IFID_Flush  = 1'b1;
        end
    end

    assign HiLo_Valid = r_hilo_valid;

    stall_perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_perf_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (IDEX_Bubble),
        .clr   (Stall_Clear),
        .count (Stall_Count)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed, table-driven bench for hazard_stall_controller.
// Main instance: latency 4, 4-bit stall counter. Second instance: latency 1.
module tb_hazard_stall_controller;

    logic       clk;
    logic       reset;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_Rt;
    logic [4:0] IFID_Rs;
    logic [4:0] IFID_Rt;
    logic       IFID_UsesRt;
    logic       IFID_ReadsHiLo;
    logic       MulDiv_Start;
    logic       Branch_Taken;
    logic       Jump;
    logic       Stall_Clear;

    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MulDiv_Busy, HiLo_Valid;
    logic [3:0] Stall_Count;

    logic        PC_Write1, IFID_Write1, IFID_Flush1, IDEX_Bubble1, MulDiv_Busy1, HiLo_Valid1;
    logic [15:0] Stall_Count1;

    int n_err;
    int n_chk;

    hazard_stall_controller #(.MULDIV_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IFID_ReadsHiLo(IFID_ReadsHiLo), .MulDiv_Start(MulDiv_Start),
        .Branch_Taken(Branch_Taken), .Jump(Jump), .Stall_Clear(Stall_Clear),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .MulDiv_Busy(MulDiv_Busy),
        .HiLo_Valid(HiLo_Valid), .Stall_Count(Stall_Count)
    );

    hazard_stall_controller #(.MULDIV_LATENCY(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IFID_ReadsHiLo(IFID_ReadsHiLo), .MulDiv_Start(MulDiv_Start),
        .Branch_Taken(Branch_Taken), .Jump(Jump), .Stall_Clear(Stall_Clear),
        .PC_Write(PC_Write1), .IFID_Write(IFID_Write1), .IFID_Flush(IFID_Flush1),
        .IDEX_Bubble(IDEX_Bubble1), .MulDiv_Busy(MulDiv_Busy1),
        .HiLo_Valid(HiLo_Valid1), .Stall_Count(Stall_Count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       hilo;
        logic       st;
        logic       br;
        logic       jmp;
        logic       clr;
        logic       pcw;
        logic       ifw;
        logic       fl;
        logic       bub;
        logic       busy;
        logic       hv;
        logic [3:0] cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t v(input int mr, ert, rs, rt, uses, hilo, st, br, jmp, clr,
                               input int pcw, ifw, fl, bub, busy, hv, cnt);
        vec_t r;
        r.mr = mr[0]; r.ert = ert[4:0]; r.rs = rs[4:0]; r.rt = rt[4:0];
        r.uses = uses[0]; r.hilo = hilo[0]; r.st = st[0]; r.br = br[0];
        r.jmp = jmp[0]; r.clr = clr[0];
        r.pcw = pcw[0]; r.ifw = ifw[0]; r.fl = fl[0]; r.bub = bub[0];
        r.busy = busy[0]; r.hv = hv[0]; r.cnt = cnt[3:0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        IDEX_MemRead   = x.mr;
        IDEX_Rt        = x.ert;
        IFID_Rs        = x.rs;
        IFID_Rt        = x.rt;
        IFID_UsesRt    = x.uses;
        IFID_ReadsHiLo = x.hilo;
        MulDiv_Start   = x.st;
        Branch_Taken   = x.br;
        Jump           = x.jmp;
        Stall_Clear    = x.clr;
    endtask

    task automatic idle();
        drive(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_err = 0;
        n_chk = 0;

        //            mr ert rs rt us hl st br jp cl | pcw ifw fl bub busy hv cnt
        vecs[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0);
        vecs[1]  = v(1, 8, 8, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
        vecs[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 1);
        vecs[3]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 1);
        vecs[4]  = v(1, 9, 3, 9, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 1);
        vecs[5]  = v(1, 9, 3, 9, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 1);
        vecs[6]  = v(1, 8, 8, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 1, 2);
        vecs[7]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 0, 0, 1, 3);
        vecs[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0, 1, 3);
        vecs[9]  = v(1, 8, 8, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 1, 3);
        vecs[10] = v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 1, 1, 0, 0, 1, 4);
        vecs[11] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 4);
        vecs[12] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 4);
        vecs[13] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 5);
        vecs[14] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 6);
        vecs[15] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 7);
        vecs[16] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 8);
        vecs[17] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 8);
        vecs[18] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 1, 0, 8);
        vecs[19] = v(0, 0, 0, 0, 0, 0, 1, 0, 1, 0,   0, 0, 0, 1, 1, 0, 9);
        vecs[20] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 1, 0, 10);
        vecs[21] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 1, 0, 11);
        vecs[22] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 12);
        vecs[23] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 1, 0, 12);
        vecs[24] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 12);
        vecs[25] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 12);
        vecs[26] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 12);
        vecs[27] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 12);
        vecs[28] = v(1, 8, 8, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 1, 12);
        vecs[29] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 0);

        // Reset values while reset is held.
        reset = 1'b1;
        idle();
        #3;
        chk("rst busy", 32'(MulDiv_Busy), 32'd0);
        chk("rst hilo_valid", 32'(HiLo_Valid), 32'd1);
        chk("rst stall_count", 32'(Stall_Count), 32'd0);
        chk("rst pc_write", 32'(PC_Write), 32'd1);
        chk("rst bubble", 32'(IDEX_Bubble), 32'd0);
        reset = 1'b0;
        next_cycle();

        // Table: each vector is one clock; outputs checked mid-cycle.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d pc_write", i),    32'(PC_Write),    32'(vecs[i].pcw));
            chk($sformatf("v%0d ifid_write", i),  32'(IFID_Write),  32'(vecs[i].ifw));
            chk($sformatf("v%0d ifid_flush", i),  32'(IFID_Flush),  32'(vecs[i].fl));
            chk($sformatf("v%0d bubble", i),      32'(IDEX_Bubble), 32'(vecs[i].bub));
            chk($sformatf("v%0d busy", i),        32'(MulDiv_Busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d hilo_valid", i),  32'(HiLo_Valid),  32'(vecs[i].hv));
            chk($sformatf("v%0d stall_count", i), 32'(Stall_Count), 32'(vecs[i].cnt));
            next_cycle();
        end

        // Saturation: 20 load-use stalls on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            drive(v(1,8,8,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("sat count", 32'(Stall_Count), 32'd15);
        next_cycle();
        drive(v(1,8,8,0,0,0,0,0,0,1, 0,0,0,0,0,0,0));
        @(negedge clk);
        chk("sat clr bubble", 32'(IDEX_Bubble), 32'd1);
        chk("sat before clr", 32'(Stall_Count), 32'd15);
        next_cycle();
        idle();
        @(negedge clk);
        chk("sat after clr", 32'(Stall_Count), 32'd0);
        next_cycle();

        // Latency-1 unit: MULDIV lasts exactly one cycle.
        drive(v(0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0));
        @(negedge clk);
        chk("lat1 issue busy", 32'(MulDiv_Busy1), 32'd0);
        next_cycle();
        drive(v(0,0,0,0,0,1,0,0,0,0, 0,0,0,0,0,0,0));
        @(negedge clk);
        chk("lat1 busy", 32'(MulDiv_Busy1), 32'd1);
        chk("lat1 hilo_valid", 32'(HiLo_Valid1), 32'd0);
        chk("lat1 bubble", 32'(IDEX_Bubble1), 32'd1);
        chk("lat4 busy c1", 32'(MulDiv_Busy), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lat1 done busy", 32'(MulDiv_Busy1), 32'd0);
        chk("lat1 done hilo_valid", 32'(HiLo_Valid1), 32'd1);
        chk("lat1 done bubble", 32'(IDEX_Bubble1), 32'd0);

        // Main unit is now in its second MULDIV cycle: reset asynchronously.
        chk("mid busy", 32'(MulDiv_Busy), 32'd1);
        chk("mid hilo_valid", 32'(HiLo_Valid), 32'd0);
        chk("mid count", 32'(Stall_Count), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst busy", 32'(MulDiv_Busy), 32'd0);
        chk("arst hilo_valid", 32'(HiLo_Valid), 32'd1);
        chk("arst count", 32'(Stall_Count), 32'd0);
        chk("arst bubble", 32'(IDEX_Bubble), 32'd0);
        reset = 1'b0;
        idle();
        next_cycle();
        @(negedge clk);
        chk("post rst busy", 32'(MulDiv_Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
